// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with blanked slot starts and frame-aligned value
// commit, so a new value never appears partway through a scan frame.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE = 8,
  parameter int unsigned BLANK    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  sel,
  output logic [3:0]  an_n,
  output logic [15:0] disp_value,
  output logic        frame_done,
  output logic        load_ack
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK);

  typedef enum logic [1:0] {StOff, StBlank, StShow} state_e;

  state_e      state;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] staging_q, staging_d;
  logic        pending_q, pending_d;
  logic [15:0] disp_q, disp_d;
  logic        frame_done_q, frame_done_d;
  logic        load_ack_q, load_ack_d;
  logic        slot_end, wrap, commit;

  always_comb begin
    if (!en) begin
      state = StOff;
    end else if (cnt_q < BlankEnd) begin
      state = StBlank;
    end else begin
      state = StShow;
    end
  end

  assign slot_end = en && (cnt_q == CntMax);
  assign wrap     = slot_end && (idx_q == 2'd3);
  // A commit always takes the staging value held before this edge; a coincident load
  // only refills staging and stays pending.
  assign commit   = pending_q && (!en || wrap);

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    staging_d    = staging_q;
    pending_d    = pending_q;
    disp_d       = disp_q;
    frame_done_d = wrap;
    load_ack_d   = commit;

    if (!en) begin
      cnt_d = '0;
    end else if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (commit) begin
      disp_d    = staging_q;
      pending_d = 1'b0;
    end
    if (load) begin
      staging_d = value_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      staging_q    <= 16'h0000;
      pending_q    <= 1'b0;
      disp_q       <= 16'h0000;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign sel = 4'b0001 << idx_q;

  // Anode drive follows digit_en combinationally so masking takes effect mid-slot.
  always_comb begin
    case (state)
      StShow:  an_n = ~(sel & digit_en);
      default: an_n = 4'b1111;
    endcase
  end

  assign disp_value = disp_q;
  assign frame_done = frame_done_q;
  assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios followed by random traffic,
// all compared cycle by cycle against a frame-position reference model.
module tb_display_scan_ctrl;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  sel;
  logic [3:0]  an_n;
  logic [15:0] disp_value;
  logic        frame_done;
  logic        load_ack;

  display_scan_ctrl #(
    .PRESCALE(P),
    .BLANK   (B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .value_in  (value_in),
    .digit_en  (digit_en),
    .sel       (sel),
    .an_n      (an_n),
    .disp_value(disp_value),
    .frame_done(frame_done),
    .load_ack  (load_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: position within a 4*P-cycle frame plus the load/commit bookkeeping.
  int          m_pos;
  logic [15:0] m_stage;
  logic [15:0] m_disp;
  logic        m_pend;
  logic        m_fd;
  logic        m_ack;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos   = 0;
    m_stage = 16'h0000;
    m_disp  = 16'h0000;
    m_pend  = 1'b0;
    m_fd    = 1'b0;
    m_ack   = 1'b0;
  endtask

  task automatic check_outputs();
    logic [3:0] es;
    logic [3:0] ean;
    es  = 4'b0001 << (m_pos / P);
    ean = (!en || (m_pos % P) < B) ? 4'hF : ~(es & digit_en);
    chk("sel",        {12'h000, sel},           {12'h000, es});
    chk("an_n",       {12'h000, an_n},          {12'h000, ean});
    chk("disp_value", disp_value,               m_disp);
    chk("frame_done", {15'h0000, frame_done},   {15'h0000, m_fd});
    chk("load_ack",   {15'h0000, load_ack},     {15'h0000, m_ack});
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [15:0] v);
    logic wrap;
    logic commit;
    wrap   = e && (m_pos == FRAME - 1);
    commit = m_pend && (!e || wrap);
    m_fd   = wrap;
    m_ack  = commit;
    if (commit) begin
      m_disp = m_stage;
      m_pend = 1'b0;
    end
    if (l) begin
      m_stage = v;
      m_pend  = 1'b1;
    end
    if (e) m_pos = (m_pos + 1) % FRAME;
    else   m_pos = (m_pos / P) * P;
  endtask

  // Called at a falling edge: drive, check, clock, update model, return at next falling edge.
  task automatic step(input logic e, input logic l, input logic [15:0] v);
    en       = e;
    load     = l;
    value_in = v;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(e, l, v);
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (m_pos != target && n < 4 * FRAME) begin
      step(1'b1, 1'b0, 16'h0000);
      n++;
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan with all digits enabled.
    repeat (FRAME + 8) step(1'b1, 1'b0, 16'h0000);

    // Load during digit 1 waits for the frame wrap.
    run_to(P + 3);
    step(1'b1, 1'b1, 16'h1234);
    run_to(0);
    chk("commit_1234", disp_value, 16'h1234);

    // Two loads in one frame: last one wins.
    run_to(5);
    step(1'b1, 1'b1, 16'hAAAA);
    run_to(2 * P);
    step(1'b1, 1'b1, 16'h5555);
    run_to(0);
    chk("commit_5555", disp_value, 16'h5555);

    // Load exactly on the wrap edge while another value is pending.
    run_to(P);
    step(1'b1, 1'b1, 16'h1111);
    run_to(FRAME - 1);
    step(1'b1, 1'b1, 16'hBEEF);
    chk("wrap_commit_1111", disp_value, 16'h1111);
    run_to(FRAME - 1);
    step(1'b1, 1'b0, 16'h0000);
    chk("next_wrap_beef", disp_value, 16'hBEEF);

    // Digit 2 masked for a whole frame.
    digit_en = 4'b1011;
    repeat (FRAME) step(1'b1, 1'b0, 16'h0000);
    digit_en = 4'hF;

    // Disable mid-slot on digit 2 with a load, then resume.
    run_to(2 * P + 5);
    step(1'b0, 1'b1, 16'h00FF);
    repeat (9) step(1'b0, 1'b0, 16'h0000);
    chk("off_commit_00ff", disp_value, 16'h00FF);
    repeat (P + 4) step(1'b1, 1'b0, 16'h0000);

    // Reset in the middle of operation discards a pending load.
    step(1'b1, 1'b1, 16'hCAFE);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 2) step(1'b1, 1'b0, 16'h0000);
    chk("reset_drops_pending", disp_value, 16'h0000);

    // Random traffic.
    repeat (800) begin
      logic e;
      logic l;
      e        = ($urandom_range(0, 9) != 0);
      l        = ($urandom_range(0, 7) == 0);
      digit_en = 4'($urandom);
      step(e, l, 16'($urandom));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 8, meaning clock cycles per digit slot; legal range 4..65535.
REQ-002 SHALL have parameter BLANK, default 2, meaning anode-off cycles at the start of each slot; legal range 1..PRESCALE-2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, scan enable.
REQ-006 SHALL have port load, input, 1, single-cycle request to display value_in.
REQ-007 SHALL have port value_in, input, 16, four BCD/hex nibbles; digit i is value_in[4i+3:4i].
REQ-008 SHALL have port digit_en, input, 4, per-digit enable; bit i low blanks digit i.
REQ-009 SHALL have port sel, output, 4, one-hot digit select to the nibble selector; bit i selects n[4i+3:4i].
REQ-010 SHALL have port an_n, output, 4, active-low anode drive.
REQ-011 SHALL have port disp_value, output, 16, committed value feeding the selector n input.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse per completed 4-digit frame.
REQ-013 SHALL have port load_ack, output, 1, one-cycle pulse when disp_value is updated.

Function
REQ-014 SHALL keep a slot counter cnt (0..PRESCALE-1) and a digit index idx (0..3); sel SHALL equal the one-hot of idx at all times, never zero and never multi-hot.
REQ-015 SHALL implement states OFF, BLANK and SHOW: OFF when en=0; BLANK when en=1 and cnt<BLANK; SHOW when en=1 and cnt>=BLANK.
REQ-016 In OFF, cnt SHALL be held at 0, idx SHALL hold, and an_n SHALL be 4'b1111.
REQ-017 In BLANK, an_n SHALL be 4'b1111.
REQ-018 In SHOW, an_n[i] SHALL be 0 only when sel[i]=1 and digit_en[i]=1; all other bits SHALL be 1.
REQ-019 While en=1, cnt SHALL increment each cycle; at cnt=PRESCALE-1, cnt SHALL return to 0 and idx SHALL advance 0->1->2->3->0.
REQ-020 frame_done SHALL pulse for exactly one cycle, registered, in the cycle after the 3->0 wrap edge.
REQ-021 On en 1->0 mid-slot, the next cycle SHALL be OFF; on re-enable, scanning SHALL resume at BLANK of the held idx.
REQ-022 A load pulse SHALL capture value_in into a staging register and set a pending flag; a later load before commit SHALL overwrite staging (last load wins).
REQ-023 While en=1, a pending value SHALL commit to disp_value only on the 3->0 wrap edge, preventing mid-frame tearing; load_ack SHALL pulse in the same cycle disp_value changes.
REQ-024 A load coincident with the wrap edge SHALL NOT commit on that edge: the previously pending staging value (if any) commits, and the new value stays pending until the next wrap.
REQ-025 While en=0, a pending value SHALL commit on the next clock edge, with load_ack pulsing.
REQ-026 digit_en changes SHALL affect an_n combinationally within the current SHOW cycle and SHALL NOT alter cnt or idx.

Reset
REQ-027 On rst_n=0, asynchronously: sel=4'b0001, an_n=4'b1111, disp_value=16'h0000, frame_done=0, load_ack=0, cnt=0, idx=0, staging=0, pending=0.
REQ-028 On rst_n release, the first enabled cycle SHALL be BLANK of digit 0; reset asserted mid-operation SHALL discard any pending load.

Verification (PRESCALE=8, BLANK=2)
REQ-029 Reset, en=1, digit_en=4'hF -> an_n=1111 for 2 cycles, then 1110 for 6 cycles, then sel=0010 with 2 blank cycles, continuing; frame_done pulses every 32 cycles.
REQ-030 load with value_in=16'h1234 at idx=1 -> disp_value stays 0000 until the 3->0 wrap, then becomes 1234 with a single load_ack pulse.
REQ-031 Loads of 16'hAAAA then 16'h5555 within one frame -> only 5555 commits, with one load_ack.
REQ-032 load 16'hBEEF on the exact wrap edge while 16'h1111 is pending -> 1111 commits now, BEEF commits at the next wrap (32 cycles later).
REQ-033 digit_en=4'b1011, full frame -> an_n[2] stays 1 throughout; sel still visits 0100 for 8 cycles.
REQ-034 en dropped at idx=2, cnt=5 for 10 cycles with a load 16'h00FF -> an_n=1111, sel=0100 held, disp_value=00FF next cycle; re-enable -> 2 blank cycles on digit 2.
